// File: rtl/alu_arbiter.sv
// Two-requester arbiter for one shared ALU (ALU_ARB_RR_EN selects round-robin, else fixed r0 priority).
// Grant->done in 2 cycles (1 for illegal ops); requests are held until done and ignored while busy.
module alu_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [1:0]          req_i,
  input  logic [5:0]          aluop_i,
  input  logic [11:0]         funct_i,
  input  logic [2*DATA_W-1:0] src1_i,
  input  logic [2*DATA_W-1:0] src2_i,
  output logic [1:0]          done_o,
  output logic [DATA_W-1:0]   result_o,
  output logic                zero_o,
  output logic                err_o,
  output logic                busy_o,
  output logic [3:0]          alu_ctrl_o,
  output logic [DATA_W-1:0]   alu_src1_o,
  output logic [DATA_W-1:0]   alu_src2_o,
  input  logic [DATA_W-1:0]   alu_result_i,
  input  logic                alu_zero_i
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] CTRL_ILL = 4'b1111;

  state_t              state;
  state_t              state_nxt;
  logic                win;
  logic [3:0]          ctrl_q;
  logic [DATA_W-1:0]   src1_q;
  logic [DATA_W-1:0]   src2_q;
  logic                err_q;
  logic [DATA_W-1:0]   res_q;
  logic                zero_q;

  logic                win_sel;
  logic [2:0]          sel_op;
  logic [5:0]          sel_fn;
  logic [3:0]          sel_code;
  logic                sel_ill;
  logic                grant;

  function automatic logic [3:0] decode(input logic [2:0] op, input logic [5:0] fn);
    logic [3:0] code;
    code = CTRL_ILL;
    case (op)
      3'b000: begin
        case (fn)
          6'h20:   code = 4'b0010;
          6'h22:   code = 4'b0110;
          6'h24:   code = 4'b0000;
          6'h25:   code = 4'b0001;
          6'h2A:   code = 4'b0111;
          default: code = CTRL_ILL;
        endcase
      end
      3'b001, 3'b010, 3'b011: code = 4'b0010;
      3'b100:                 code = 4'b0111;
      3'b101:                 code = 4'b0110;
      default:                code = CTRL_ILL;
    endcase
    return code;
  endfunction

`ifdef ALU_ARB_RR_EN
  // Pointer names the requester preferred on a tie.
  logic ptr;
  assign win_sel = (req_i == 2'b11) ? ptr : ~req_i[0];
`else
  assign win_sel = ~req_i[0];
`endif

  assign grant    = (state == IDLE) && (req_i != 2'b00);
  assign sel_op   = win_sel ? aluop_i[5:3] : aluop_i[2:0];
  assign sel_fn   = win_sel ? funct_i[11:6] : funct_i[5:0];
  assign sel_code = decode(sel_op, sel_fn);
  assign sel_ill  = (sel_code == CTRL_ILL);

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE: begin
        if (req_i != 2'b00) state_nxt = sel_ill ? RESP : EXEC;
        else                state_nxt = IDLE;
      end
      EXEC:    state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      win    <= 1'b0;
      ctrl_q <= '0;
      src1_q <= '0;
      src2_q <= '0;
      err_q  <= 1'b0;
      res_q  <= '0;
      zero_q <= 1'b0;
`ifdef ALU_ARB_RR_EN
      ptr    <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (grant) begin
        win    <= win_sel;
        // An illegal code is never stored, so the ALU can never see 1111.
        ctrl_q <= sel_ill ? 4'b0000 : sel_code;
        src1_q <= win_sel ? src1_i[2*DATA_W-1:DATA_W] : src1_i[DATA_W-1:0];
        src2_q <= win_sel ? src2_i[2*DATA_W-1:DATA_W] : src2_i[DATA_W-1:0];
        err_q  <= sel_ill;
        res_q  <= '0;
        zero_q <= 1'b0;
`ifdef ALU_ARB_RR_EN
        ptr    <= ~win_sel;
`endif
      end
      if (state == EXEC) begin
        res_q  <= alu_result_i;
        zero_q <= alu_zero_i;
      end
    end
  end

  always_comb begin
    done_o     = 2'b00;
    result_o   = '0;
    zero_o     = 1'b0;
    err_o      = 1'b0;
    alu_ctrl_o = 4'b0000;
    alu_src1_o = '0;
    alu_src2_o = '0;
    busy_o     = (state != IDLE);
    if (state == EXEC) begin
      alu_ctrl_o = ctrl_q;
      alu_src1_o = src1_q;
      alu_src2_o = src2_q;
    end
    if (state == RESP) begin
      done_o[win] = 1'b1;
      result_o    = res_q;
      zero_o      = zero_q;
      err_o       = err_q;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized self-checking bench for alu_arbiter with a transaction-level reference model.
module tb_alu_arbiter;
  localparam int DW = 32;
`ifdef ALU_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_i;
  logic [1:0]      req_q;
  logic [2:0]      op [2];
  logic [5:0]      fn [2];
  logic [DW-1:0]   s1 [2];
  logic [DW-1:0]   s2 [2];
  logic [5:0]      aluop_i;
  logic [11:0]     funct_i;
  logic [2*DW-1:0] src1_i;
  logic [2*DW-1:0] src2_i;
  logic [1:0]      done_o;
  logic [DW-1:0]   result_o;
  logic            zero_o;
  logic            err_o;
  logic            busy_o;
  logic [3:0]      alu_ctrl_o;
  logic [DW-1:0]   alu_src1_o;
  logic [DW-1:0]   alu_src2_o;
  logic [DW-1:0]   alu_result_i;
  logic            alu_zero_i;

  int checks = 0;
  int failures = 0;
  bit ptr_m = 1'b0;

  always #5 clk = ~clk;

  assign aluop_i = {op[1], op[0]};
  assign funct_i = {fn[1], fn[0]};
  assign src1_i  = {s1[1], s1[0]};
  assign src2_i  = {s2[1], s2[0]};

  alu_arbiter #(.DATA_W(DW)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_q), .aluop_i(aluop_i), .funct_i(funct_i),
    .src1_i(src1_i), .src2_i(src2_i), .done_o(done_o), .result_o(result_o),
    .zero_o(zero_o), .err_o(err_o), .busy_o(busy_o), .alu_ctrl_o(alu_ctrl_o),
    .alu_src1_o(alu_src1_o), .alu_src2_o(alu_src2_o),
    .alu_result_i(alu_result_i), .alu_zero_i(alu_zero_i)
  );

  // Operation kinds as named by the decode table.
  typedef enum int {K_ADD, K_SUB, K_AND, K_OR, K_SLT, K_ILL} kind_t;

  function automatic kind_t op_kind(input logic [2:0] o, input logic [5:0] f);
    if (o == 3'd0) begin
      if (f == 6'h20) return K_ADD;
      if (f == 6'h22) return K_SUB;
      if (f == 6'h24) return K_AND;
      if (f == 6'h25) return K_OR;
      if (f == 6'h2A) return K_SLT;
      return K_ILL;
    end
    if (o <= 3'd3) return K_ADD;
    if (o == 3'd4) return K_SLT;
    if (o == 3'd5) return K_SUB;
    return K_ILL;
  endfunction

  function automatic logic [3:0] kind_code(input kind_t k);
    case (k)
      K_ADD:   return 4'b0010;
      K_SUB:   return 4'b0110;
      K_AND:   return 4'b0000;
      K_OR:    return 4'b0001;
      K_SLT:   return 4'b0111;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [DW-1:0] kind_calc(input kind_t k, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (k)
      K_ADD:   return a + b;
      K_SUB:   return a - b;
      K_AND:   return a & b;
      K_OR:    return a | b;
      K_SLT:   return ($signed(a) < $signed(b)) ? DW'(1) : DW'(0);
      default: return '0;
    endcase
  endfunction

  // Stand-in for the shared ALU.
  always_comb begin
    case (alu_ctrl_o)
      4'b0010: alu_result_i = kind_calc(K_ADD, alu_src1_o, alu_src2_o);
      4'b0110: alu_result_i = kind_calc(K_SUB, alu_src1_o, alu_src2_o);
      4'b0000: alu_result_i = kind_calc(K_AND, alu_src1_o, alu_src2_o);
      4'b0001: alu_result_i = kind_calc(K_OR,  alu_src1_o, alu_src2_o);
      4'b0111: alu_result_i = kind_calc(K_SLT, alu_src1_o, alu_src2_o);
      default: alu_result_i = '0;
    endcase
    alu_zero_i = (alu_result_i == '0);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic new_op(input int r);
    logic [5:0] ftab [6];
    ftab[0] = 6'h20; ftab[1] = 6'h22; ftab[2] = 6'h24;
    ftab[3] = 6'h25; ftab[4] = 6'h2A; ftab[5] = 6'($urandom);
    op[r] = 3'($urandom_range(0, 7));
    fn[r] = ftab[$urandom_range(0, 5)];
    s1[r] = $urandom;
    s2[r] = ($urandom_range(0, 3) == 0) ? s1[r] : $urandom;
  endtask

  // Called at a falling edge with the DUT idle and req_q already set.
  task automatic serve(input bit drop);
    int            w;
    kind_t         k;
    logic [DW-1:0] a0;
    logic [DW-1:0] b0;
    logic [DW-1:0] er;
    logic [1:0]    ed;
    if (req_q == 2'b11) w = RR ? int'(ptr_m) : 0;
    else                w = req_q[0] ? 0 : 1;
    k  = op_kind(op[w], fn[w]);
    a0 = s1[w];
    b0 = s2[w];
    er = kind_calc(k, a0, b0);
    ed = 2'b01 << w;
    @(negedge clk);
    if (k != K_ILL) begin
      chk("exec_ctrl", alu_ctrl_o, kind_code(k));
      chk("exec_src1", alu_src1_o, a0);
      chk("exec_src2", alu_src2_o, b0);
      chk("exec_done", done_o, 2'b00);
      chk("exec_result", result_o, 0);
      chk("exec_busy", busy_o, 1'b1);
      s1[w] = $urandom;
      @(negedge clk);
    end
    chk("resp_done", done_o, ed);
    chk("resp_result", result_o, er);
    chk("resp_zero", zero_o, (k != K_ILL) && (er == '0));
    chk("resp_err", err_o, k == K_ILL);
    chk("resp_ctrl", alu_ctrl_o, 4'b0000);
    chk("resp_busy", busy_o, 1'b1);
    ptr_m = (w == 0);
    if (drop) req_q[w] = 1'b0;
    @(negedge clk);
    chk("idle_done", done_o, 2'b00);
    chk("idle_busy", busy_o, 1'b0);
  endtask

  initial begin
    rst_i = 1'b1;
    req_q = 2'b00;
    for (int r = 0; r < 2; r++) begin
      op[r] = '0; fn[r] = '0; s1[r] = '0; s2[r] = '0;
    end
    repeat (2) @(negedge clk);
    chk("rst_done", done_o, 2'b00);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_result", result_o, 0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_ctrl", alu_ctrl_o, 4'b0000);
    rst_i = 1'b0;

    // Single add, beq compare, illegal funct.
    op[0] = 3'b000; fn[0] = 6'h20; s1[0] = 5; s2[0] = 7; req_q = 2'b01;
    serve(1'b1);
    op[1] = 3'b101; fn[1] = 6'h00; s1[1] = 32'h1234; s2[1] = 32'h1234; req_q = 2'b10;
    serve(1'b1);
    op[0] = 3'b000; fn[0] = 6'h3F; req_q = 2'b01;
    serve(1'b1);

    // Both held continuously, then r0 drops.
    op[0] = 3'b001; s1[0] = 10; s2[0] = 3;
    op[1] = 3'b101; s1[1] = 9;  s2[1] = 4;
    req_q = 2'b11;
    repeat (4) serve(1'b0);
    repeat (2) serve(1'b1);

    // Reset during EXEC aborts the op; next tie goes to r0.
    op[1] = 3'b010; s1[1] = 1; s2[1] = 2; req_q = 2'b10;
    @(negedge clk);
    chk("abort_exec_busy", busy_o, 1'b1);
    rst_i = 1'b1;
    req_q = 2'b00;
    @(negedge clk);
    chk("abort_done", done_o, 2'b00);
    chk("abort_busy", busy_o, 1'b0);
    rst_i = 1'b0;
    ptr_m = 1'b0;
    @(negedge clk);
    chk("abort_no_pulse", done_o, 2'b00);
    op[0] = 3'b011; s1[0] = 20; s2[0] = 22; req_q = 2'b11;
    serve(1'b1);
    serve(1'b1);

    // Randomized traffic with pending requests.
    for (int i = 0; i < 80; i++) begin
      for (int r = 0; r < 2; r++) begin
        if (!req_q[r] && ($urandom_range(0, 1) == 1)) begin
          new_op(r);
          req_q[r] = 1'b1;
        end
      end
      if (req_q == 2'b00) begin
        new_op(0);
        req_q[0] = 1'b1;
      end
      serve(1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
